mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the MIPS core's instruction-fetch port and its data-access port. The block sits between the core's `inst_ram_*` / `data_ram_*` interfaces and a unified memory. Per transaction it:
- arbitrates between the two requesters,
- sequences the fixed-latency RAM read or write,
- returns read data with a one-cycle valid pulse,
- drives per-port stall signals that the pipeline hazard logic uses to freeze fetch or MEM.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous RAM
//               between an instruction-fetch port and a data-access port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_valid,
    output logic          inst_stall,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_valid,
    output logic          data_stall,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_RD_I       = 2'd1;
    localparam logic [1:0] c_RD_D       = 2'd2;
    localparam logic [1:0] c_WR_ACK     = 2'd3;
    localparam logic       c_GRANT_INST = 1'b0;
    localparam logic [2:0] c_LAT_LOAD   = 3'(RD_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       w_grant_any;
    logic       w_grant_data;
    logic       w_rd_done;

    // On a tie the port that did not win last time gets the RAM.
    assign w_grant_any  = inst_req | data_req;
    assign w_grant_data = data_req & (~inst_req | (last_grant_q == c_GRANT_INST));
    assign w_rd_done    = (lat_cnt_q == 3'd0);

    always_ff @(posedge clka) begin
        if (!rst) begin
            state_q      <= c_IDLE;
            lat_cnt_q    <= 3'd0;
            last_grant_q <= c_GRANT_INST;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant_any) begin
                    last_grant_d = w_grant_data;
                    if (w_grant_data && data_we) begin
                        state_d = c_WR_ACK;
                    end else begin
                        lat_cnt_d = c_LAT_LOAD;
                        state_d   = w_grant_data ? c_RD_D : c_RD_I;
                    end
                end
            end
            c_RD_I, c_RD_D: begin
                if (!w_rd_done) begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_WR_ACK: state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        inst_valid = 1'b0;
        data_valid = 1'b0;
        inst_rdata = '0;
        data_rdata = '0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state_q)
            c_IDLE: begin
                // Requests are sampled only here; later changes are ignored.
                if (w_grant_any) begin
                    ram_en   = 1'b1;
                    ram_addr = w_grant_data ? data_addr : inst_addr;
                    if (w_grant_data && data_we) begin
                        ram_we    = 1'b1;
                        ram_wdata = data_wdata;
                    end
                end
            end
            c_RD_I: begin
                if (w_rd_done) begin
                    inst_valid = 1'b1;
                    inst_rdata = ram_rdata;
                end
            end
            c_RD_D: begin
                if (w_rd_done) begin
                    data_valid = 1'b1;
                    data_rdata = ram_rdata;
                end
            end
            c_WR_ACK: data_valid = 1'b1;
            default: begin
                inst_valid = 1'b0;
                data_valid = 1'b0;
            end
        endcase
    end

    assign inst_stall = inst_req & ~inst_valid;
    assign data_stall = data_req & ~data_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter at RD_LAT=1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clka = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata;

    logic [31:0] inst_rdata1, data_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        inst_valid1, inst_stall1, data_valid1, data_stall1, ram_en1, ram_we1;
    logic [31:0] inst_rdata3, data_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
    logic        inst_valid3, inst_stall3, data_valid3, data_stall3, ram_en3, ram_we3;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] pipe3a, pipe3b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clka = ~clka;

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
        .clka(clka), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata1),
        .inst_valid(inst_valid1), .inst_stall(inst_stall1),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata1),
        .data_valid(data_valid1), .data_stall(data_stall1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
        .clka(clka), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata3),
        .inst_valid(inst_valid3), .inst_stall(inst_stall3),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata3),
        .data_valid(data_valid3), .data_stall(data_stall3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    function automatic logic [31:0] ram_init(int idx);
        return (idx == 4) ? 32'h2008_0005 : (32'h1000_0000 + 32'(idx));
    endfunction

    // RAM models: word-indexed, contents reloaded while reset is low.
    always @(posedge clka) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= ram_init(i);
        end else if (ram_en1 && ram_we1) begin
            mem1[ram_addr1[9:2]] <= ram_wdata1;
        end
        ram_rdata1 <= mem1[ram_addr1[9:2]];
    end

    always @(posedge clka) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= ram_init(i);
        end else if (ram_en3 && ram_we3) begin
            mem3[ram_addr3[9:2]] <= ram_wdata3;
        end
        pipe3a     <= mem3[ram_addr3[9:2]];
        pipe3b     <= pipe3a;
        ram_rdata3 <= pipe3b;
    end

    task automatic step;
        @(posedge clka);
        #1;
    endtask

    task automatic idle(input int n);
        inst_req = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        total_cnt++; if (ram_en1 !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_en1); else pass_cnt++;
        total_cnt++; if (inst_valid1 !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid1); else pass_cnt++;
        total_cnt++; if (data_valid1 !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid1); else pass_cnt++;
        total_cnt++; if (inst_rdata1 !== 32'h0) $display("FAIL reset_inst_rdata: got %h want 0", inst_rdata1); else pass_cnt++;
        total_cnt++; if (ram_en3 !== 1'b0) $display("FAIL reset_ram_en3: got %b want 0", ram_en3); else pass_cnt++;
        step();
        rst = 1'b1;
        @(negedge clka);
        total_cnt++; if (ram_we1 !== 1'b0) $display("FAIL post_reset_ram_we: got %b want 0", ram_we1); else pass_cnt++;
        total_cnt++; if (data_valid1 !== 1'b0) $display("FAIL post_reset_data_valid: got %b want 0", data_valid1); else pass_cnt++;
        idle(2);
    endtask

    task automatic test_tie;
        step();
        inst_req = 1'b1; inst_addr = 32'h0;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        @(negedge clka);
        total_cnt++; if (ram_en1 !== 1'b1) $display("FAIL tie_ram_en: got %b want 1", ram_en1); else pass_cnt++;
        total_cnt++; if (ram_addr1 !== 32'h100) $display("FAIL tie_first_grant_addr: got %h want 100", ram_addr1); else pass_cnt++;
        total_cnt++; if (ram_we1 !== 1'b0) $display("FAIL tie_ram_we: got %b want 0", ram_we1); else pass_cnt++;
        total_cnt++; if ({inst_stall1, data_stall1} !== 2'b11) $display("FAIL tie_stalls: got %b want 11", {inst_stall1, data_stall1}); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if (data_valid1 !== 1'b1) $display("FAIL tie_data_valid: got %b want 1", data_valid1); else pass_cnt++;
        total_cnt++; if (data_rdata1 !== 32'h1000_0040) $display("FAIL tie_data_rdata: got %h want 10000040", data_rdata1); else pass_cnt++;
        total_cnt++; if (data_stall1 !== 1'b0) $display("FAIL tie_data_stall_done: got %b want 0", data_stall1); else pass_cnt++;
        total_cnt++; if (inst_valid1 !== 1'b0) $display("FAIL tie_inst_early: got %b want 0", inst_valid1); else pass_cnt++;
        step();
        data_req = 1'b0;
        @(negedge clka);
        total_cnt++; if ({ram_en1, ram_addr1} !== {1'b1, 32'h0}) $display("FAIL tie_second_grant: got en=%b addr=%h want en=1 addr=0", ram_en1, ram_addr1); else pass_cnt++;
        total_cnt++; if ({data_valid1, data_rdata1} !== 33'h0) $display("FAIL tie_data_rdata_idle: got v=%b d=%h want 0/0", data_valid1, data_rdata1); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if (inst_valid1 !== 1'b1) $display("FAIL tie_inst_valid: got %b want 1", inst_valid1); else pass_cnt++;
        total_cnt++; if (inst_rdata1 !== 32'h1000_0000) $display("FAIL tie_inst_rdata: got %h want 10000000", inst_rdata1); else pass_cnt++;
        step();
        inst_req = 1'b1; inst_addr = 32'h4;
        data_req = 1'b1; data_addr = 32'h104;
        @(negedge clka);
        total_cnt++; if (ram_addr1 !== 32'h104) $display("FAIL tie_again_data_wins: got %h want 104", ram_addr1); else pass_cnt++;
        idle(8);
    endtask

    task automatic test_single_fetch;
        step();
        inst_req = 1'b1; inst_addr = 32'h10;
        @(negedge clka);
        total_cnt++; if ({ram_en1, ram_addr1} !== {1'b1, 32'h10}) $display("FAIL fetch_grant: got en=%b addr=%h want en=1 addr=10", ram_en1, ram_addr1); else pass_cnt++;
        total_cnt++; if (inst_stall1 !== 1'b1) $display("FAIL fetch_stall_T: got %b want 1", inst_stall1); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if (inst_valid1 !== 1'b1) $display("FAIL fetch_valid: got %b want 1", inst_valid1); else pass_cnt++;
        total_cnt++; if (inst_rdata1 !== 32'h2008_0005) $display("FAIL fetch_rdata: got %h want 20080005", inst_rdata1); else pass_cnt++;
        total_cnt++; if (inst_stall1 !== 1'b0) $display("FAIL fetch_stall_T1: got %b want 0", inst_stall1); else pass_cnt++;
        total_cnt++; if (ram_en1 !== 1'b0) $display("FAIL fetch_ram_en_T1: got %b want 0", ram_en1); else pass_cnt++;
        step();
        inst_req = 1'b0;
        @(negedge clka);
        total_cnt++; if ({inst_valid1, inst_rdata1} !== 33'h0) $display("FAIL fetch_pulse_end: got v=%b d=%h want 0/0", inst_valid1, inst_rdata1); else pass_cnt++;
        idle(8);
    endtask

    task automatic test_write;
        step();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'hDEAD_BEEF;
        @(negedge clka);
        total_cnt++; if ({ram_en1, ram_we1} !== 2'b11) $display("FAIL write_en_we: got %b want 11", {ram_en1, ram_we1}); else pass_cnt++;
        total_cnt++; if (ram_addr1 !== 32'h40) $display("FAIL write_addr: got %h want 40", ram_addr1); else pass_cnt++;
        total_cnt++; if (ram_wdata1 !== 32'hDEAD_BEEF) $display("FAIL write_wdata: got %h want deadbeef", ram_wdata1); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if (data_valid1 !== 1'b1) $display("FAIL write_valid: got %b want 1", data_valid1); else pass_cnt++;
        total_cnt++; if (ram_en1 !== 1'b0) $display("FAIL write_ram_en_T1: got %b want 0", ram_en1); else pass_cnt++;
        total_cnt++; if (data_rdata1 !== 32'h0) $display("FAIL write_rdata_zero: got %h want 0", data_rdata1); else pass_cnt++;
        step();
        data_we = 1'b0;
        @(negedge clka);
        total_cnt++; if ({ram_en1, ram_we1, ram_addr1} !== {2'b10, 32'h40}) $display("FAIL readback_grant: got en=%b we=%b addr=%h want 1/0/40", ram_en1, ram_we1, ram_addr1); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if ({data_valid1, data_rdata1} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL readback_data: got v=%b d=%h want 1/deadbeef", data_valid1, data_rdata1); else pass_cnt++;
        idle(8);
    endtask

    task automatic test_rdlat3;
        step();
        inst_req = 1'b1; inst_addr = 32'h30;
        @(negedge clka);
        total_cnt++; if ({ram_en3, ram_addr3} !== {1'b1, 32'h30}) $display("FAIL lat3_grant: got en=%b addr=%h want 1/30", ram_en3, ram_addr3); else pass_cnt++;
        step();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
        @(negedge clka);
        total_cnt++; if ({ram_en3, inst_valid3} !== 2'b00) $display("FAIL lat3_T1: got en=%b v=%b want 0/0", ram_en3, inst_valid3); else pass_cnt++;
        total_cnt++; if ({inst_stall3, data_stall3} !== 2'b11) $display("FAIL lat3_stalls_T1: got %b want 11", {inst_stall3, data_stall3}); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if ({ram_en3, inst_valid3, inst_stall3} !== 3'b001) $display("FAIL lat3_T2: got en/v/stall=%b want 001", {ram_en3, inst_valid3, inst_stall3}); else pass_cnt++;
        step();
        @(negedge clka);
        total_cnt++; if ({inst_valid3, inst_stall3, ram_en3} !== 3'b100) $display("FAIL lat3_T3: got v/stall/en=%b want 100", {inst_valid3, inst_stall3, ram_en3}); else pass_cnt++;
        total_cnt++; if (inst_rdata3 !== 32'h1000_000C) $display("FAIL lat3_rdata: got %h want 1000000c", inst_rdata3); else pass_cnt++;
        step();
        inst_req = 1'b0;
        @(negedge clka);
        total_cnt++; if ({ram_en3, ram_we3, ram_addr3} !== {2'b10, 32'h80}) $display("FAIL lat3_data_grant_T4: got en=%b we=%b addr=%h want 1/0/80", ram_en3, ram_we3, ram_addr3); else pass_cnt++;
        total_cnt++; if (inst_valid3 !== 1'b0) $display("FAIL lat3_inst_single_pulse: got %b want 0", inst_valid3); else pass_cnt++;
        repeat (3) step();
        @(negedge clka);
        total_cnt++; if ({data_valid3, data_rdata3} !== {1'b1, 32'h1000_0020}) $display("FAIL lat3_data_valid_T7: got v=%b d=%h want 1/10000020", data_valid3, data_rdata3); else pass_cnt++;
        idle(8);
    endtask

    task automatic test_addr_change;
        step();
        inst_req = 1'b1; inst_addr = 32'h20;
        @(negedge clka);
        total_cnt++; if ({ram_addr1, ram_addr3} !== {32'h20, 32'h20}) $display("FAIL addrchg_grant: got %h/%h want 20/20", ram_addr1, ram_addr3); else pass_cnt++;
        step();
        inst_addr = 32'h24;
        @(negedge clka);
        total_cnt++; if ({inst_valid1, inst_rdata1} !== {1'b1, 32'h1000_0008}) $display("FAIL addrchg_lat1: got v=%b d=%h want 1/10000008", inst_valid1, inst_rdata1); else pass_cnt++;
        repeat (2) step();
        @(negedge clka);
        total_cnt++; if ({inst_valid3, inst_rdata3} !== {1'b1, 32'h1000_0008}) $display("FAIL addrchg_lat3: got v=%b d=%h want 1/10000008", inst_valid3, inst_rdata3); else pass_cnt++;
        idle(8);
    endtask

    task automatic test_reset_mid_read;
        step();
        inst_req = 1'b1; inst_addr = 32'h30;
        @(negedge clka);
        total_cnt++; if (ram_en3 !== 1'b1) $display("FAIL rstmid_grant: got %b want 1", ram_en3); else pass_cnt++;
        step();
        rst = 1'b0;
        @(negedge clka);
        total_cnt++; if ({inst_stall3, inst_valid3} !== 2'b10) $display("FAIL rstmid_stall_in_reset: got stall/v=%b want 10", {inst_stall3, inst_valid3}); else pass_cnt++;
        step();
        inst_req = 1'b0;
        @(negedge clka);
        total_cnt++; if (inst_valid3 !== 1'b0) $display("FAIL rstmid_T2_valid: got %b want 0", inst_valid3); else pass_cnt++;
        step();
        rst = 1'b1;
        @(negedge clka);
        total_cnt++; if (inst_valid3 !== 1'b0) $display("FAIL rstmid_T3_no_valid: got %b want 0", inst_valid3); else pass_cnt++;
        step();
        inst_req = 1'b1; inst_addr = 32'h34;
        @(negedge clka);
        total_cnt++; if ({ram_en3, ram_addr3} !== {1'b1, 32'h34}) $display("FAIL rstmid_regrant: got en=%b addr=%h want 1/34", ram_en3, ram_addr3); else pass_cnt++;
        repeat (3) step();
        @(negedge clka);
        total_cnt++; if ({inst_valid3, inst_rdata3} !== {1'b1, 32'h1000_000D}) $display("FAIL rstmid_new_read: got v=%b d=%h want 1/1000000d", inst_valid3, inst_rdata3); else pass_cnt++;
        idle(8);
    endtask

    initial begin
        rst        = 1'b0;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        inst_addr  = 32'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        test_reset();
        test_tie();
        test_single_fetch();
        test_write();
        test_rdlat3();
        test_addr_change();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
